// File: rtl/ex_muldiv_pkg.sv
// Shared decode constants, FSM encoding and small arithmetic helpers
// for the execute-stage RV32M multiply/divide unit.
package ex_muldiv_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement negation of a data word.
  function automatic logic [DATA_W-1:0] neg_word(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Conditional negation used for operand magnitudes and result sign fixups.
  function automatic logic [DATA_W-1:0] cond_neg(input logic               neg,
                                                 input logic [DATA_W-1:0] v);
    return neg ? neg_word(v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, 32 cycles.
// quotient/remainder present the result of the step taken this cycle; valid when done=1.
module ex_muldiv_div_core
  import ex_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic              running;
  logic [4:0]        count;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dsr_q;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep if non-negative.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    diff    = shifted - {1'b0, dsr_q};
    if (diff[DATA_W] == 1'b0) begin
      remainder = diff[DATA_W-1:0];
      quotient  = {quo_q[DATA_W-2:0], 1'b1};
    end else begin
      remainder = shifted[DATA_W-1:0];
      quotient  = {quo_q[DATA_W-2:0], 1'b0};
    end
  end

  assign done = running & (count == 5'd0);

  // Iteration state: load on start, step while running, stop on flush or last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      count   <= 5'd0;
      rem_q   <= {DATA_W{1'b0}};
      quo_q   <= {DATA_W{1'b0}};
      dsr_q   <= {DATA_W{1'b0}};
    end else if (flush) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      count   <= 5'd31;
      rem_q   <= {DATA_W{1'b0}};
      quo_q   <= dividend;
      dsr_q   <= divisor;
    end else if (running) begin
      rem_q <= remainder;
      quo_q <= quotient;
      if (count == 5'd0) begin
        running <= 1'b0;
      end else begin
        count <= count - 5'd1;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage RV32M multiply/divide unit: single-cycle multiplies and divide
// special cases, 32-cycle restoring divide that stalls the front of the pipeline.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [6:0]      opcode_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            rd_we_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            in_ready,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            rd_we,
  output logic [4:0]      rd_addr
);

  state_t state;
  state_t next_state;

  logic [2:0]      op_f3;
  logic            op_rd_we;
  logic [4:0]      op_rd_addr;
  logic            op_sign_q;
  logic            op_sign_r;
  logic            done_pulse;

  logic            is_m;
  logic            accept;
  logic            capture;
  logic            load_out;
  logic            div_start;
  logic [XLEN-1:0] next_result;
  logic            next_rd_we;
  logic [4:0]      next_rd_addr;

  logic            a_signed;
  logic            b_signed;
  logic [63:0]     mul_a;
  logic [63:0]     mul_b;
  logic [63:0]     product;
  logic [XLEN-1:0] mul_res;

  logic            div_signed;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;
  logic            sign_q;
  logic            sign_r;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  logic            core_done;
  logic [XLEN-1:0] core_quo;
  logic [XLEN-1:0] core_rem;
  logic [XLEN-1:0] div_res;

  assign is_m   = in_valid & (opcode_i == OPCODE_OP) & (funct7_i == FUNCT7_MULDIV);
  assign accept = is_m & in_ready & ~flush_i;

  // Sign-extend to 64 bits per operand signedness; the low 64 product bits are then exact.
  assign a_signed = ~(funct3_i[1] & funct3_i[0]);
  assign b_signed = ~funct3_i[1];
  assign mul_a    = {{32{a_signed & rs1_data_i[XLEN-1]}}, rs1_data_i};
  assign mul_b    = {{32{b_signed & rs2_data_i[XLEN-1]}}, rs2_data_i};
  assign product  = mul_a * mul_b;
  assign mul_res  = (funct3_i[1:0] == 2'b00) ? product[31:0] : product[63:32];

  assign div_signed = ~funct3_i[0];
  assign div_zero   = (rs2_data_i == {XLEN{1'b0}});
  assign div_ovf    = div_signed & (rs1_data_i == 32'h8000_0000) & (rs2_data_i == 32'hFFFF_FFFF);
  assign sign_q     = div_signed & (rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1]);
  assign sign_r     = div_signed & rs1_data_i[XLEN-1];
  assign abs_a      = cond_neg(sign_r, rs1_data_i);
  assign abs_b      = cond_neg(div_signed & rs2_data_i[XLEN-1], rs2_data_i);

  // Special-case result: divide-by-zero first, then signed overflow.
  always_comb begin
    special_res = {XLEN{1'b0}};
    if (div_zero) begin
      special_res = funct3_i[1] ? rs1_data_i : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_res = funct3_i[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      special_res = {XLEN{1'b0}};
    end
  end

  assign div_res = op_f3[1] ? cond_neg(op_sign_r, core_rem) : cond_neg(op_sign_q, core_quo);

  ex_muldiv_div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .start     (div_start),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  // Next-state and output-load decode; flush overrides every transition.
  always_comb begin
    next_state   = state;
    capture      = 1'b0;
    load_out     = 1'b0;
    div_start    = 1'b0;
    next_result  = result;
    next_rd_we   = rd_we;
    next_rd_addr = rd_addr;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          capture = 1'b1;
          if (!funct3_i[2]) begin
            next_state   = ST_DONE;
            load_out     = 1'b1;
            next_result  = mul_res;
            next_rd_we   = rd_we_i;
            next_rd_addr = rd_addr_i;
          end else if (div_zero || div_ovf) begin
            next_state   = ST_DONE;
            load_out     = 1'b1;
            next_result  = special_res;
            next_rd_we   = rd_we_i;
            next_rd_addr = rd_addr_i;
          end else begin
            next_state = ST_DIV;
            div_start  = 1'b1;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (flush_i) begin
          next_state = ST_IDLE;
        end else if (core_done) begin
          next_state   = ST_DONE;
          load_out     = 1'b1;
          next_result  = div_res;
          next_rd_we   = op_rd_we;
          next_rd_addr = op_rd_addr;
        end else begin
          next_state = ST_DIV;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register plus captured op context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_f3      <= 3'b000;
      op_rd_we   <= 1'b0;
      op_rd_addr <= 5'd0;
      op_sign_q  <= 1'b0;
      op_sign_r  <= 1'b0;
      done_pulse <= 1'b0;
      result     <= {XLEN{1'b0}};
      rd_we      <= 1'b0;
      rd_addr    <= 5'd0;
    end else begin
      state      <= next_state;
      done_pulse <= load_out;
      if (capture) begin
        op_f3      <= funct3_i;
        op_rd_we   <= rd_we_i;
        op_rd_addr <= rd_addr_i;
        op_sign_q  <= sign_q;
        op_sign_r  <= sign_r;
      end
      if (load_out) begin
        result  <= next_result;
        rd_we   <= next_rd_we;
        rd_addr <= next_rd_addr;
      end
    end
  end

  // A flush arriving in the DONE cycle kills the result as well.
  assign out_valid = done_pulse & ~flush_i;
  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        rd_we_in;
  logic [4:0]  rd_addr_in;
  logic        flush;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic [31:0] result;
  logic        rd_we;
  logic [4:0]  rd_addr;

  int checks   = 0;
  int failures = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .opcode_i   (opcode),
    .funct7_i   (funct7),
    .funct3_i   (funct3),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .rd_we_i    (rd_we_in),
    .rd_addr_i  (rd_addr_in),
    .flush_i    (flush),
    .in_ready   (in_ready),
    .busy       (busy),
    .out_valid  (out_valid),
    .result     (result),
    .rd_we      (rd_we),
    .rd_addr    (rd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] == 1'b0) return 1;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present one M bundle at a negedge; returns in the first cycle after acceptance.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic we);
    in_valid   = 1'b1;
    opcode     = 7'b0110011;
    funct7     = 7'b0000001;
    funct3     = f3;
    rs1        = a;
    rs2        = b;
    rd_we_in   = we;
    rd_addr_in = rd;
    check_val("ready_at_issue", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic we);
    logic [31:0] exp_res;
    int exp_lat;
    int lat;
    bit seen;
    bit stall_ok;
    exp_res  = ref_model(f3, a, b);
    exp_lat  = ref_latency(f3, a, b);
    start_op(f3, a, b, rd, we);
    lat      = 1;
    seen     = 1'b0;
    stall_ok = 1'b1;
    while (!seen && lat <= 40) begin
      if (!busy || in_ready) stall_ok = 1'b0;
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    check_val({tag, "_seen"}, {31'd0, seen}, 32'd1);
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
    check_val({tag, "_res"}, result, exp_res);
    check_val({tag, "_rd"}, {27'd0, rd_addr}, {27'd0, rd});
    check_val({tag, "_we"}, {31'd0, rd_we}, {31'd0, we});
    @(negedge clk);
    check_val({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    bit saw;
    rst = 1'b1; in_valid = 1'b0; opcode = 7'd0; funct7 = 7'd0; funct3 = 3'd0;
    rs1 = 32'd0; rs2 = 32'd0; rd_we_in = 1'b0; rd_addr_in = 5'd0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_result", result, 32'd0);
    check_val("rst_rdwe", {31'd0, rd_we}, 32'd0);
    check_val("rst_rdaddr", {27'd0, rd_addr}, 32'd0);
    check_val("rst_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 1'b1);
    check_val("mul_const", result, 32'hFFFF_FFEB);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
    check_val("mulhu_const", result, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
    check_val("mulhsu_const", result, 32'hFFFF_FFFF);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5, 1'b1);
    check_val("mulh_const", result, 32'h4000_0000);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
    check_val("div_const", result, 32'hFFFF_FFFD);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1);
    check_val("rem_const", result, 32'hFFFF_FFFF);
    run_op("divu0", 3'd5, 32'd9, 32'd0, 5'd8, 1'b1);
    run_op("rem0", 3'd6, 32'd5, 32'd0, 5'd10, 1'b1);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1);

    // Flush in the 10th DIV cycle.
    start_op(3'd4, 32'd1000, 32'd7, 5'd13, 1'b1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_val("flush_ready", {31'd0, in_ready}, 32'd1);
    check_val("flush_busy", {31'd0, busy}, 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) saw = 1'b1;
      @(negedge clk);
    end
    check_val("flush_noout", {31'd0, saw}, 32'd0);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd14, 1'b1);

    // Non-M bundle is ignored.
    in_valid = 1'b1; opcode = 7'b0110011; funct7 = 7'd0; funct3 = 3'd0;
    rs1 = 32'd5; rs2 = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("ign_busy", {31'd0, busy}, 32'd0);
    check_val("ign_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_val("ign_valid2", {31'd0, out_valid}, 32'd0);

    // Reset mid-divide.
    start_op(3'd5, 32'd12345, 32'd17, 5'd21, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("mrst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mrst_result", result, 32'd0);
    check_val("mrst_rdwe", {31'd0, rd_we}, 32'd0);
    check_val("mrst_rdaddr", {27'd0, rd_addr}, 32'd0);
    check_val("mrst_ready", {31'd0, in_ready}, 32'd1);
    check_val("mrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      int sel;
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) b = -32'($urandom_range(1, 15));
      run_op("rand", f3, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
